// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the instruction-memory program loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam int LEN_BYTES = 2;

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and status of the loader.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) ();
  logic                  start;
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_write_data;
  logic                  cpu_hold;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport master (
    input  start, in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_write_data,
    output cpu_hold, busy, done, error
  );

  modport slave (
    output start, in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_write_data,
    input  cpu_hold, busy, done, error
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Assembles little-endian bytes into a word; word_next already contains the byte being loaded.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  load_byte,
  input  logic [7:0]            byte_in,
  output logic [DATA_WIDTH-1:0] word_next,
  output logic                  word_full
);
  localparam int BPW  = bytes_per_word(DATA_WIDTH);
  localparam int IDXW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(BPW - 1);

  logic [DATA_WIDTH-1:0] lanes;
  logic [IDXW-1:0]       byte_idx;

  always_comb begin
    word_next = lanes;
    if (load_byte) word_next[{byte_idx, 3'b000} +: 8] = byte_in;
  end

  assign word_full = load_byte && (byte_idx == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lanes    <= '0;
      byte_idx <= '0;
    end else if (clear) begin
      lanes    <= '0;
      byte_idx <= '0;
    end else if (load_byte) begin
      lanes    <= word_next;
      byte_idx <= word_full ? '0 : byte_idx + IDXW'(1);
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Length-prefixed byte-stream loader: writes N words to imem from address 0, holding the CPU meanwhile.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  imem_loader_if.master bus
);
  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

  state_t                  state;
  logic [LEN_BYTES*8-1:0]  len;
  logic [ADDR_WIDTH:0]     word_idx;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;

  logic                    xfer;
  logic                    load_byte;
  logic                    word_full;
  logic [DATA_WIDTH-1:0]   word_next;
  logic [LEN_BYTES*8-1:0]  len_next;
  logic [16:0]             word_cnt_next;

  // Handshake and status come from registered state only.
  assign bus.in_ready = (state == LEN_LO) || (state == LEN_HI) || (state == DATA);
  assign bus.busy     = (state == LEN_LO) || (state == LEN_HI) || (state == DATA) || (state == WRITE);
  assign bus.cpu_hold = bus.busy || (state == ERR);
  assign bus.done     = (state == DONE);
  assign bus.error    = (state == ERR);

  assign bus.imem_we         = we_q;
  assign bus.imem_addr       = addr_q;
  assign bus.imem_write_data = wdata_q;

  assign xfer          = bus.in_valid && bus.in_ready;
  assign load_byte     = xfer && (state == DATA);
  assign len_next      = {bus.in_data, len[7:0]};
  assign word_cnt_next = 17'(word_idx) + 17'd1;

  imem_loader_byte_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (state == LEN_HI),
    .load_byte (load_byte),
    .byte_in   (bus.in_data),
    .word_next (word_next),
    .word_full (word_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      len      <= '0;
      word_idx <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      we_q <= 1'b0;
      case (state)
        IDLE, DONE, ERR: if (bus.start) state <= LEN_LO;
        LEN_LO: if (xfer) begin
          len[7:0] <= bus.in_data;
          state    <= LEN_HI;
        end
        LEN_HI: if (xfer) begin
          len[15:8] <= bus.in_data;
          word_idx  <= '0;
          if (len_next == '0)                 state <= DONE;
          else if (17'(len_next) > MAX_WORDS) state <= ERR;
          else                                state <= DATA;
        end
        // Capture the completed word as it is accepted so WRITE drives it immediately.
        DATA: if (word_full) begin
          we_q    <= 1'b1;
          addr_q  <= word_idx[ADDR_WIDTH-1:0];
          wdata_q <= word_next;
          state   <= WRITE;
        end
        WRITE: begin
          word_idx <= word_idx + 1'b1;
          state    <= (word_cnt_next == 17'(len)) ? DONE : DATA;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a stream-level reference model.
module tb_imem_loader;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b0;

  imem_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t         wr_q[$];
  logic [DW-1:0] mem[DEPTH];
  logic [7:0]  stream[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          start_at = -1;

  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wr_q.push_back('{bus.imem_addr, bus.imem_write_data});
      mem[bus.imem_addr] = bus.imem_write_data;
    end
  end

  // Reference model: word count and little-endian words straight from the byte stream.
  function automatic int stream_n();
    return int'({stream[1], stream[0]});
  endfunction

  function automatic logic [DW-1:0] exp_word(input int i);
    logic [DW-1:0] w;
    for (int b = 0; b < DW / 8; b++) w[8*b +: 8] = stream[2 + (DW / 8) * i + b];
    return w;
  endfunction

  task automatic push_len(input int n);
    stream.delete();
    stream.push_back(8'(n));
    stream.push_back(8'(n >> 8));
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    for (int b = 0; b < DW / 8; b++) stream.push_back(w[8*b +: 8]);
  endtask

  task automatic make_random(input int n);
    push_len(n);
    for (int i = 0; i < n; i++) push_word(DW'($urandom));
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Entered and left on a negedge; returns one negedge after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (bus.in_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL byte_accept_timeout got in_ready=%b exp 1 within 50 cycles", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic run_load(input int max_gap);
    int n;
    bit ok_len;
    int w;
    n = stream_n();
    ok_len = (n >= 1) && (n <= DEPTH);
    for (int k = 0; k < stream.size(); k++) begin
      bus.start = (k == start_at);
      send_byte(stream[k], int'($urandom_range(max_gap, 0)));
      bus.start = 1'b0;
      if (ok_len && k >= 2 && ((k - 2) % (DW / 8)) == (DW / 8 - 1)) begin
        w = (k - 2) / (DW / 8);
        vectors++;
        if (bus.imem_we !== 1'b1 || bus.in_ready !== 1'b0 ||
            bus.imem_addr !== AW'(w) || bus.imem_write_data !== exp_word(w)) begin
          miscompares++;
          $display("FAIL write_pulse word=%0d got we=%b rdy=%b addr=%0d data=%h exp we=1 rdy=0 addr=%0d data=%h",
                   w, bus.imem_we, bus.in_ready, bus.imem_addr, bus.imem_write_data, w, exp_word(w));
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    vectors++;
    if ({bus.done, bus.error, bus.cpu_hold, bus.busy, bus.in_ready, bus.imem_we} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_flags got %b exp 000000",
               {bus.done, bus.error, bus.cpu_hold, bus.busy, bus.in_ready, bus.imem_we});
    end
    vectors++;
    if (bus.imem_addr !== '0 || bus.imem_write_data !== '0) begin
      miscompares++;
      $display("FAIL reset_bus got addr=%0d data=%h exp 0", bus.imem_addr, bus.imem_write_data);
    end
    @(negedge clk);
    rst = 1'b0;
    pulse_start();
    send_byte(8'h05, 0);
    vectors++;
    if ({bus.done, bus.error, bus.cpu_hold, bus.busy, bus.in_ready} !== 5'b00111) begin
      miscompares++;
      $display("FAIL len_hi_status got %b exp 00111",
               {bus.done, bus.error, bus.cpu_hold, bus.busy, bus.in_ready});
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({bus.done, bus.error, bus.cpu_hold, bus.busy, bus.in_ready, bus.imem_we} !== 6'b0 ||
        bus.imem_addr !== '0) begin
      miscompares++;
      $display("FAIL async_reset got flags=%b addr=%0d exp 000000 addr=0",
               {bus.done, bus.error, bus.cpu_hold, bus.busy, bus.in_ready, bus.imem_we}, bus.imem_addr);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_normal();
    wr_q.delete();
    stream.delete();
    push_len(2);
    push_word(32'h0000_0013);
    push_word(32'h0010_0093);
    pulse_start();
    run_load(0);
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.done, bus.error, bus.cpu_hold, bus.busy, bus.in_ready} !== 5'b10000) begin
      miscompares++;
      $display("FAIL normal_status got %b exp 10000",
               {bus.done, bus.error, bus.cpu_hold, bus.busy, bus.in_ready});
    end
    vectors++;
    if (wr_q.size() != 2) begin
      miscompares++;
      $display("FAIL normal_count got %0d exp 2", wr_q.size());
    end
    vectors++;
    if (mem[0] !== 32'h0000_0013 || mem[1] !== 32'h0010_0093) begin
      miscompares++;
      $display("FAIL normal_readback got %h %h exp 00000013 00100093", mem[0], mem[1]);
    end
  endtask

  task automatic test_zero_len();
    wr_q.delete();
    push_len(0);
    pulse_start();
    run_load(0);
    vectors++;
    if ({bus.done, bus.error, bus.cpu_hold, bus.busy, bus.in_ready} !== 5'b10000) begin
      miscompares++;
      $display("FAIL zero_len_status got %b exp 10000",
               {bus.done, bus.error, bus.cpu_hold, bus.busy, bus.in_ready});
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (wr_q.size() != 0) begin
      miscompares++;
      $display("FAIL zero_len_writes got %0d exp 0", wr_q.size());
    end
  endtask

  task automatic test_oversize();
    wr_q.delete();
    push_len(DEPTH + 1);
    pulse_start();
    run_load(0);
    repeat (5) @(negedge clk);
    vectors++;
    if ({bus.done, bus.error, bus.cpu_hold, bus.busy, bus.in_ready} !== 5'b01100 || wr_q.size() != 0) begin
      miscompares++;
      $display("FAIL oversize got status=%b writes=%0d exp 01100 writes=0",
               {bus.done, bus.error, bus.cpu_hold, bus.busy, bus.in_ready}, wr_q.size());
    end
    make_random(1);
    pulse_start();
    run_load(1);
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.done, bus.error, bus.cpu_hold} !== 3'b100 || wr_q.size() != 1) begin
      miscompares++;
      $display("FAIL oversize_recover got done/err/hold=%b writes=%0d exp 100 writes=1",
               {bus.done, bus.error, bus.cpu_hold}, wr_q.size());
    end else begin
      vectors++;
      if (wr_q[0].a !== '0 || wr_q[0].d !== exp_word(0)) begin
        miscompares++;
        $display("FAIL oversize_recover_data got %0d:%h exp 0:%h", wr_q[0].a, wr_q[0].d, exp_word(0));
      end
    end
  endtask

  task automatic test_gaps();
    wr_q.delete();
    make_random(3);
    pulse_start();
    run_load(4);
    repeat (2) @(negedge clk);
    vectors++;
    if (wr_q.size() != 3 || bus.done !== 1'b1) begin
      miscompares++;
      $display("FAIL gaps_count got writes=%0d done=%b exp 3 1", wr_q.size(), bus.done);
    end
    for (int i = 0; i < wr_q.size() && i < 3; i++) begin
      vectors++;
      if (wr_q[i].a !== AW'(i) || wr_q[i].d !== exp_word(i)) begin
        miscompares++;
        $display("FAIL gaps_word%0d got %0d:%h exp %0d:%h", i, wr_q[i].a, wr_q[i].d, i, exp_word(i));
      end
    end
  endtask

  task automatic test_reset_mid_word();
    wr_q.delete();
    make_random(2);
    pulse_start();
    for (int k = 0; k < 2 + DW / 8 + 2; k++) send_byte(stream[k], int'($urandom_range(2, 0)));
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({bus.cpu_hold, bus.busy, bus.in_ready, bus.imem_we} !== 4'b0) begin
      miscompares++;
      $display("FAIL mid_word_reset_flags got %b exp 0000",
               {bus.cpu_hold, bus.busy, bus.in_ready, bus.imem_we});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (wr_q.size() != 1 || wr_q[0].d !== exp_word(0)) begin
      miscompares++;
      $display("FAIL mid_word_partial got writes=%0d exp 1 (word 0 only)", wr_q.size());
    end
    wr_q.delete();
    push_len(4);
    for (int i = 0; i < 4; i++) push_word(32'hA000_0000 + DW'(i));
    pulse_start();
    run_load(1);
    repeat (2) @(negedge clk);
    vectors++;
    if (wr_q.size() != 4 || bus.done !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_word_reload got writes=%0d done=%b exp 4 1", wr_q.size(), bus.done);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (mem[i] !== 32'hA000_0000 + DW'(i)) begin
        miscompares++;
        $display("FAIL mid_word_mem%0d got %h exp %h", i, mem[i], 32'hA000_0000 + DW'(i));
      end
    end
  endtask

  task automatic test_random_start_ignored();
    int n;
    for (int r = 0; r < 4; r++) begin
      wr_q.delete();
      n = int'($urandom_range(6, 1));
      make_random(n);
      start_at = int'($urandom_range(stream.size() - 1, 0));
      pulse_start();
      run_load(3);
      start_at = -1;
      repeat (2) @(negedge clk);
      vectors++;
      if (wr_q.size() != n || bus.done !== 1'b1) begin
        miscompares++;
        $display("FAIL random%0d_count got writes=%0d done=%b exp %0d 1", r, wr_q.size(), bus.done, n);
      end
      for (int i = 0; i < wr_q.size() && i < n; i++) begin
        vectors++;
        if (wr_q[i].a !== AW'(i) || wr_q[i].d !== exp_word(i)) begin
          miscompares++;
          $display("FAIL random%0d_word%0d got %0d:%h exp %0d:%h", r, i, wr_q[i].a, wr_q[i].d, i, exp_word(i));
        end
      end
    end
  endtask

  task automatic test_full_memory();
    int bad;
    wr_q.delete();
    make_random(DEPTH);
    pulse_start();
    run_load(0);
    repeat (2) @(negedge clk);
    vectors++;
    if (wr_q.size() != DEPTH || bus.done !== 1'b1) begin
      miscompares++;
      $display("FAIL full_count got writes=%0d done=%b exp %0d 1", wr_q.size(), bus.done, DEPTH);
    end
    vectors++;
    if (wr_q.size() != 0 && wr_q[wr_q.size() - 1].a !== AW'(DEPTH - 1)) begin
      miscompares++;
      $display("FAIL full_last_addr got %0d exp %0d", wr_q[wr_q.size() - 1].a, DEPTH - 1);
    end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== exp_word(i)) bad++;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL full_readback got %0d bad words exp 0", bad);
    end
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #1;
    test_reset();
    test_normal();
    test_zero_len();
    test_oversize();
    test_gaps();
    test_reset_mid_word();
    test_random_start_ignored();
    test_full_memory();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader that drives the instruction memory write port (we/addr/write_data).
- Accepts a length-prefixed little-endian byte stream (e.g. from a UART receiver) over a valid/ready handshake.
- Packs the bytes into DATA_WIDTH words and writes them to sequential instruction-memory addresses starting at 0.
- Holds the processor (cpu_hold) for the duration of a load so fetch never sees a half-written program.

Parameters:
- ADDR_WIDTH, 10, instruction memory address width; must match the instruction memory instance.
- DATA_WIDTH, 32, instruction word width; must be a multiple of 8.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  single-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  loader can accept a byte; a byte transfers when in_valid & in_ready at posedge.
- imem_we  output  1  instruction memory write enable.
- imem_addr  output  ADDR_WIDTH  instruction memory word address.
- imem_write_data  output  DATA_WIDTH  instruction word to write.
- cpu_hold  output  1  high while a load is in progress or has failed.
- busy  output  1  high in LEN_LO, LEN_HI, DATA and WRITE.
- done  output  1  level; last load completed successfully.
- error  output  1  level; last load rejected (length too large).

Behaviour:
- Reset (async, immediate):
  - state = IDLE.
  - in_ready, imem_we, cpu_hold, busy, done and error all 0.
  - imem_addr = 0, imem_write_data = 0.
  - Word counter, length register and byte index cleared.
- Stream format:
  - Bytes 0-1: word count N, 16-bit little-endian.
  - Then N*BYTES_PER_WORD bytes; each word is little-endian (first byte -> bits [7:0]).
- FSM states and transitions:
  - IDLE: in_ready=0, cpu_hold=0. start -> LEN_LO.
  - LEN_LO: in_ready=1, cpu_hold=1. Byte accepted -> len[7:0], go to LEN_HI.
  - LEN_HI: in_ready=1. Byte accepted -> len[15:8], then evaluate N:
    - N==0 -> DONE.
    - N > 2^ADDR_WIDTH -> ERR.
    - Otherwise -> DATA with word_idx=0, byte_idx=0.
  - DATA: in_ready=1. Each accepted byte goes to lane byte_idx and byte_idx increments. The last byte of a word -> WRITE.
  - WRITE: exactly one cycle.
    - imem_we=1, imem_addr=word_idx[ADDR_WIDTH-1:0], imem_write_data=assembled word, in_ready=0.
    - Then word_idx++. If word_idx was N-1 -> DONE, else -> DATA.
  - DONE: done=1, cpu_hold=0, in_ready=0. start -> LEN_LO and clears done.
  - ERR: error=1, cpu_hold=1, in_ready=0. start -> LEN_LO and clears error. Only start or rst leave ERR.
- Latency and throughput:
  - imem_we asserts the cycle after the last byte of a word is accepted.
  - Peak rate is one word per BYTES_PER_WORD+1 cycles.
- Counter widths: word_idx is ADDR_WIDTH+1 bits, so N = 2^ADDR_WIDTH (full memory) is legal and the last address is 2^ADDR_WIDTH-1.
- imem_we is 0 in every state except WRITE; imem_addr and imem_write_data hold their last value otherwise.
- Boundary conditions:
  - start while busy: ignored.
  - in_valid while in_ready=0: byte not consumed; the source must hold it.
  - Gaps in in_valid: no effect on the assembled word.
  - rst mid-load: immediate return to IDLE. The partial word is discarded and never written; previously written words remain in memory.
- in_ready, busy, cpu_hold, done and error are decoded from state only (registered state, no combinational path from in_valid).

Decomposition:
- Package imem_loader_pkg holds:
  - state enum: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR.
  - LEN_BYTES = 2.
  - function bytes_per_word(DATA_WIDTH) = DATA_WIDTH/8.
- One sub-module is natural: byte_packer (shift/lane register plus byte_idx, with clear and load_byte inputs and a word_full output).
- The FSM and word counter stay in imem_loader.

Test Plan:
- Reset check: assert rst asynchronously mid-cycle -> in_ready, imem_we, cpu_hold, busy, done, error all 0 immediately; imem_addr=0.
- Normal load, N=2: start; bytes 02 00 13 00 00 00 93 00 10 00 -> writes addr0=0x00000013, then addr1=0x00100093, one imem_we pulse each; done=1, cpu_hold=0 afterwards; memory readback matches.
- Zero length: start; bytes 00 00 -> DONE the cycle after the second byte, no imem_we, cpu_hold low again.
- Oversize, ADDR_WIDTH=10: start; bytes 01 04 (N=1025) -> error=1, cpu_hold=1, in_ready=0, no writes. A following start plus a valid N=1 stream loads addr0 and sets done.
- Backpressure/gaps: random idle cycles between bytes for N=3 -> exactly 3 writes with correct data and addresses; in_ready=0 exactly in WRITE cycles; no byte lost or duplicated.
- Reset mid-word: rst after 2 data bytes of word 1 -> no write of word 1. A subsequent full N=4 load (addr 0-3 = 0xA0000000+i) writes correctly and sets done.
